// File: rtl/lane_struct_fifo_pkg.sv
// Shared parameter set, entry-width helper and the typedef-generating macro for lane_struct_fifo.
// LANE_STRUCT_FIFO_TYPEDEFS(L, W, T) declares lane_data_u and entry_t inside a parametrised scope.
`ifndef LANE_STRUCT_FIFO_PKG_SV
`define LANE_STRUCT_FIFO_PKG_SV

`define LANE_STRUCT_FIFO_TYPEDEFS(L, W, T) \
   typedef union packed { \
      logic [(L)-1:0][(W)-1:0] lane; \
      logic [(L)*(W)-1:0]      flat; \
   } lane_data_u; \
   typedef struct packed { \
      logic [(T)-1:0] tag; \
      logic [(L)-1:0] keep; \
      lane_data_u     data; \
   } entry_t;

package lane_struct_fifo_pkg;

   localparam int DEF_LANES  = 4;
   localparam int DEF_LANE_W = 8;
   localparam int DEF_TAG_W  = 3;
   localparam int DEF_DEPTH  = 8;

   function automatic int entry_w(input int lanes, input int lane_w, input int tag_w);
      return tag_w + lanes + lanes * lane_w;
   endfunction

endpackage

`endif

// File: rtl/lane_struct_fifo_if.sv
// Valid/ready write and read channels of lane_struct_fifo carrying flat entry_t vectors.
interface lane_struct_fifo_if #(
   parameter int ENTRY_W = lane_struct_fifo_pkg::entry_w(lane_struct_fifo_pkg::DEF_LANES,
                                                         lane_struct_fifo_pkg::DEF_LANE_W,
                                                         lane_struct_fifo_pkg::DEF_TAG_W)
);
   import lane_struct_fifo_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [ENTRY_W-1:0] in_entry;
   logic               out_valid;
   logic               out_ready;
   logic [ENTRY_W-1:0] out_entry;

   modport master (
      output in_valid, in_entry, out_ready,
      input  in_ready, out_valid, out_entry
   );

   modport slave (
      input  in_valid, in_entry, out_ready,
      output in_ready, out_valid, out_entry
   );
endinterface

// File: rtl/lane_struct_fifo_view.sv
// Combinational output view of a FIFO entry: zeroes lanes whose keep bit is clear, then
// optionally reverses lane and keep order. LANE_STRUCT_FIFO_CHECK_EN adds shape assertions.
module lane_struct_fifo_view
   import lane_struct_fifo_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = DEF_LANE_W,
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic [entry_w(LANES, LANE_W, TAG_W)-1:0] i_entry,
   input  logic                                     i_rev_mode,
   output logic [entry_w(LANES, LANE_W, TAG_W)-1:0] o_entry
);
   `LANE_STRUCT_FIFO_TYPEDEFS(LANES, LANE_W, TAG_W)

   entry_t w_in;
   entry_t w_masked;
   entry_t w_out;

   // Masking first, then reversal, so a reversed lane carries the keep bit it was masked with.
   always_comb begin
      w_in     = entry_t'(i_entry);
      w_masked = w_in;
      for (int i = 0; i < LANES; i++) begin
         if (w_in.keep[i]) begin
            w_masked.data.lane[i] = w_in.data.lane[i];
         end else begin
            w_masked.data.lane[i] = {LANE_W{1'b0}};
         end
      end
      w_out = w_masked;
      if (i_rev_mode) begin
         for (int i = 0; i < LANES; i++) begin
            w_out.keep[i]      = w_masked.keep[LANES-1-i];
            w_out.data.lane[i] = w_masked.data.lane[LANES-1-i];
         end
      end else begin
         w_out = w_masked;
      end
   end

   assign o_entry = w_out;

`ifdef LANE_STRUCT_FIFO_CHECK_EN
   // Constant shape checks on the entry layout.
   always_comb begin
      assert ($bits(entry_t) == TAG_W + LANES + LANES * LANE_W) else $error("entry_t width");
      assert ($size(w_in.data.lane, 1) == LANES) else $error("lane count");
      assert ($size(w_in.data.lane, 2) == LANE_W) else $error("lane width");
      assert ($high(w_in.data.lane, 1) == LANES - 1) else $error("lane high index");
      assert ($low(w_in.data.lane, 2) == 0) else $error("lane low bit");
   end
`else
`endif
endmodule

// File: rtl/lane_struct_fifo.sv
// Synchronous FIFO of entry_t records with first-word fall-through head, occupancy count and a
// sticky overflow flag. LANE_STRUCT_FIFO_CHECK_EN compiles in runtime consistency assertions.
module lane_struct_fifo
   import lane_struct_fifo_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = DEF_LANE_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int DEPTH  = DEF_DEPTH
`ifdef LANE_STRUCT_FIFO_CHECK_EN
   , parameter bit CHECK_NO_OVERFLOW = 1'b0
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   lane_struct_fifo_if.slave          bus,
   input  logic                       rev_mode,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow_err
);
   `LANE_STRUCT_FIFO_TYPEDEFS(LANES, LANE_W, TAG_W)

   localparam int ENTRY_W = entry_w(LANES, LANE_W, TAG_W);
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = $clog2(DEPTH + 1);

   entry_t          r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow_err;

   entry_t          w_in_entry;
   entry_t          w_head;
   logic [ENTRY_W-1:0] w_view_out;
   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_push;
   logic            w_pop;

   // Flags come only from the registered count; a pop while full does not open the write side.
   assign w_in_ready  = (r_count != CW'(DEPTH));
   assign w_out_valid = (r_count != {CW{1'b0}});
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;
   assign w_in_entry  = entry_t'(bus.in_entry);
   assign w_head      = r_mem[r_rd_ptr];

   // Storage array; deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in_entry;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr       <= {AW{1'b0}};
         r_rd_ptr       <= {AW{1'b0}};
         r_count        <= {CW{1'b0}};
         r_overflow_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (bus.in_valid && !w_in_ready) begin
            r_overflow_err <= 1'b1;
         end
      end
   end

   lane_struct_fifo_view #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .TAG_W  (TAG_W)
   ) u_view (
      .i_entry    (w_head),
      .i_rev_mode (rev_mode),
      .o_entry    (w_view_out)
   );

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_entry = w_view_out;
   assign count         = r_count;
   assign overflow_err  = r_overflow_err;

`ifdef LANE_STRUCT_FIFO_CHECK_EN
   // Runtime consistency of occupancy and flags.
   always_comb begin
      assert (r_count <= CW'(DEPTH)) else $error("count above DEPTH");
      assert (w_out_valid == (r_count != {CW{1'b0}})) else $error("out_valid inconsistent");
      if (CHECK_NO_OVERFLOW) begin
         assert (!(bus.in_valid && !w_in_ready)) else $error("write while full");
      end else begin
      end
   end
`else
`endif
endmodule

// File: tb/tb_lane_struct_fifo.sv
// Self-checking bench for lane_struct_fifo: vector table, directed corner sequences and
// randomized traffic scored against a queue-based reference model.
module tb_lane_struct_fifo;
   localparam int L  = 4;
   localparam int W  = 8;
   localparam int T  = 3;
   localparam int D  = 8;
   localparam int EW = T + L + L * W;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rev_mode = 1'b0;
   logic [3:0] count;
   logic       overflow_err;

   int vectors_applied = 0;
   int miscompares = 0;

   logic [EW-1:0] mq[$];
   bit            m_ovf = 1'b0;

   lane_struct_fifo_if #(.ENTRY_W(EW)) bus ();

   lane_struct_fifo #(.LANES(L), .LANE_W(W), .TAG_W(T), .DEPTH(D)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .rev_mode     (rev_mode),
      .count        (count),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic          ordy;
      logic          rev;
      logic [EW-1:0] e;
      int            exp_count;
      logic          exp_ovalid;
      logic          exp_irdy;
      logic          chk_e;
      logic [EW-1:0] exp_e;
   } vec_t;

   vec_t tbl[6];

   function automatic logic [EW-1:0] ref_view(input logic [EW-1:0] e, input logic rev);
      logic [EW-1:0] o;
      logic [L-1:0]  keep;
      int            src;
      keep = e[L*W +: L];
      o = '0;
      o[EW-1 -: T] = e[EW-1 -: T];
      for (int i = 0; i < L; i++) begin
         src = rev ? (L - 1 - i) : i;
         o[L*W + i] = keep[src];
         o[i*W +: W] = keep[src] ? e[src*W +: W] : 8'h00;
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors_applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic rev, input logic [EW-1:0] e);
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      rev_mode      = rev;
      bus.in_entry  = e;
   endtask

   task automatic model_step();
      bit full;
      bit pop;
      bit push;
      full = (mq.size() == D);
      pop  = (mq.size() > 0) && bus.out_ready;
      push = bus.in_valid && !full;
      if (bus.in_valid && full) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(bus.in_entry);
   endtask

   task automatic compare_model();
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != D));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      if (mq.size() != 0) chk("out_entry", 64'(bus.out_entry), 64'(ref_view(mq[0], rev_mode)));
   endtask

   task automatic cycle(input logic iv, input logic ordy, input logic rev, input logic [EW-1:0] e);
      drive(iv, ordy, rev, e);
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   function automatic logic [EW-1:0] rnd_entry();
      return EW'({$urandom(), $urandom()});
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, '0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, {3'd5, 4'hF, 32'h44332211}, 1, 1'b1, 1'b1, 1'b1,
                 {3'd5, 4'hF, 32'h44332211}};
      tbl[2] = '{1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, '0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, {3'd2, 4'h5, 32'hAABBCCDD}, 1, 1'b1, 1'b1, 1'b1,
                 {3'd2, 4'h5, 32'h00BB00DD}};
      tbl[4] = '{1'b0, 1'b0, 1'b1, '0, 1, 1'b1, 1'b1, 1'b1, {3'd2, 4'hA, 32'hDD00BB00}};
      tbl[5] = '{1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, '0};

      drive(1'b0, 1'b0, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_overflow", 64'(overflow_err), 64'd0);
      rst_n = 1'b1;

      // vector table
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].iv, tbl[i].ordy, tbl[i].rev, tbl[i].e);
         model_step();
         @(posedge clk);
         #1;
         chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
         chk("tbl_out_valid", 64'(bus.out_valid), 64'(tbl[i].exp_ovalid));
         chk("tbl_in_ready", 64'(bus.in_ready), 64'(tbl[i].exp_irdy));
         chk("tbl_overflow", 64'(overflow_err), 64'd0);
         if (tbl[i].chk_e) chk("tbl_out_entry", 64'(bus.out_entry), 64'(tbl[i].exp_e));
      end

      // fill to full, overflow, no pass-through, ordered drain
      for (int t = 0; t < D; t++) cycle(1'b1, 1'b0, 1'b0, {3'(t), 4'hF, $urandom()});
      chk("full_count", 64'(count), 64'd8);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      cycle(1'b1, 1'b0, 1'b0, {3'd6, 4'hF, 32'hDEADBEEF});
      chk("ovf_set", 64'(overflow_err), 64'd1);
      chk("ovf_count", 64'(count), 64'd8);
      chk("drain_tag", 64'(bus.out_entry[EW-1 -: T]), 64'd0);
      cycle(1'b1, 1'b1, 1'b0, {3'd6, 4'hF, 32'hCAFEF00D});
      chk("full_pop_no_push", 64'(count), 64'd7);
      for (int k = 1; k < D; k++) begin
         chk("drain_tag", 64'(bus.out_entry[EW-1 -: T]), 64'(k));
         cycle(1'b0, 1'b1, 1'b0, '0);
      end
      chk("drained_valid", 64'(bus.out_valid), 64'd0);
      chk("ovf_sticky", 64'(overflow_err), 64'd1);

      // simultaneous push/pop at count 3 across pointer wrap
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, rnd_entry());
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd_entry());
         chk("wrap_count", 64'(count), 64'd3);
      end

      // asynchronous reset mid-stream
      for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 1'b0, rnd_entry());
      chk("pre_rst_count", 64'(count), 64'd5);
      drive(1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      #2;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("async_rst_overflow", 64'(overflow_err), 64'd0);
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         logic iv;
         logic ordy;
         iv   = ($urandom_range(0, 99) < ((k < 200) ? 70 : 35));
         ordy = ($urandom_range(0, 99) < ((k < 200) ? 35 : 70));
         cycle(iv, ordy, 1'($urandom_range(0, 1)), rnd_entry());
         if ((k % 7) == 0 && mq.size() != 0) begin
            rev_mode = ~rev_mode;
            #1;
            chk("rev_toggle_entry", 64'(bus.out_entry), 64'(ref_view(mq[0], rev_mode)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end
endmodule

// File: doc/lane_struct_fifo.md
Name: lane_struct_fifo

Overview:
- Synchronous FIFO whose entry is a parametrised packed struct: a tag, a per-lane keep mask, and a packed union payload. The union overlays a 2-D lane view on a flat bit vector.
- Successor to the fixed-shape packed struct/union sizing checks: lane count, lane width, tag width and depth are all parameters.
- Adds valid/ready buffering, occupancy tracking, and an output lane-reverse/mask mode.
- Used as a generic record buffer between SV front-end test datapaths.

Parameters:
- LANES, 4, number of payload lanes (>=1)
- LANE_W, 8, bits per lane (>=1)
- TAG_W, 3, tag field width (>=1)
- DEPTH, 8, entries; power of two, >=2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept
- in_entry  in  TAG_W+LANES+LANES*LANE_W  packed entry_t {tag, keep, data}
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_entry  out  TAG_W+LANES+LANES*LANE_W  head entry after mode processing
- rev_mode  in  1  1 = present lanes in reversed order
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow_err  out  1  sticky; set on an in_valid attempt while full

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_n. Reset clears wr_ptr, rd_ptr, count and overflow_err, and drives out_valid=0 and in_ready=1. Storage contents are not reset. Reset asserted mid-operation discards all entries immediately; no partial state survives.
- Push: happens when in_valid && in_ready. The entry is written at wr_ptr; wr_ptr increments modulo DEPTH (log2(DEPTH)-bit wrap).
- Pop: happens when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Flags: in_ready = (count != DEPTH). out_valid = (count != 0). Both are derived only from registered count.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full: in_ready=0, and a simultaneous pop does not permit a same-cycle push (no pass-through). in_valid while full sets overflow_err; the entry is dropped. overflow_err clears only on reset.
- Empty: out_valid=0. A write into an empty FIFO becomes visible on out_entry/out_valid the next cycle (first-word fall-through, latency 1). There is no bypass in the same cycle.
- Output path, combinational from the head entry and rev_mode:
  - tag passes through unchanged.
  - Lane masking: data.lane[i] is forced to 0 when keep[i]=0.
  - rev_mode=1: output lane[i] = masked head lane[LANES-1-i], and output keep[i] = head keep[LANES-1-i].
  - rev_mode is sampled combinationally, so changing it while out_valid=1 changes out_entry in the same cycle.
- out_entry is don't-care while out_valid=0; the bench must not check it then.
- Widths: entry width is exactly TAG_W+LANES+LANES*LANE_W. The flat union member is LANES*LANE_W bits, so both union views are the same width.

Optional Feature:
- Macro: LANE_STRUCT_FIFO_CHECK_EN
- Defined: the block compiles in immediate assertions.
  - Elaboration-time: $bits(entry_t)==TAG_W+LANES+LANES*LANE_W; $size(data.lane,1)==LANES; $size(data.lane,2)==LANE_W; $high(data.lane,1)==LANES-1; $low(data.lane,2)==0.
  - Runtime, in an always_comb: count<=DEPTH; out_valid==(count!=0); !(in_valid && !in_ready) when the bench expects no overflow.
- Undefined: no assertions; functional behaviour is identical.

Decomposition:
- Package lane_struct_fifo_pkg holds:
  - parametrised typedef-generating macros, or a class-free parameter set
  - lane_data_u: packed union {lane[LANES-1:0][LANE_W-1:0]; flat[LANES*LANE_W-1:0]}
  - entry_t: packed struct {tag; keep; data}
  - a localparam function computing ENTRY_W
- One sub-module, lane_struct_fifo_view: combinational keep-masking and rev_mode lane reversal on entry_t. The FIFO core instantiates it on the head entry.

Test Plan:
- Reset then idle: count=0, out_valid=0, in_ready=1, overflow_err=0. Push tag=5, keep=4'b1111, lanes {8'h44,8'h33,8'h22,8'h11} → next cycle out_valid=1, out_entry identical, count=1.
- Fill 8 entries without popping → count=8, in_ready=0. A 9th in_valid → overflow_err=1 (sticky), count stays 8. Drain all → tags come out in write order 0..7.
- Keep mask 4'b0101 with lanes {AA,BB,CC,DD} → out lanes {00,BB,00,DD}. Set rev_mode=1 → lanes {DD,00,BB,00}, keep 4'b1010.
- Wrap-around: 20 interleaved push/pop cycles with simultaneous push and pop at count=3 → count stays 3, FIFO order preserved across pointer wrap.
- Assert rst_n low mid-stream with count=5 → count=0, out_valid=0, overflow_err=0 immediately, without waiting for a clock edge.
- LANES=1, LANE_W=1, DEPTH=2 with LANE_STRUCT_FIFO_CHECK_EN defined → elaborates, assertions pass, rev_mode has no effect.
